sar_search: RTL and testbench

//  Successive-approximation controller that sits on the B side of the 4-bit magnitude

---
 rtl/sar_search.sv | 96 +++++++++
 tb/tb_sar_search.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// Successive-approximation search controller driving the B input of a magnitude
// comparator; binary-searches operand A from the equals/larger/smaller flags.
module sar_search #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_equals,
    input  logic             cmp_larger,
    input  logic             cmp_smaller,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] found,
    output logic             error
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, TRIAL} state_t;

    state_t           state_reg;
    logic [KW-1:0]    k_reg;
    logic [WIDTH-1:0] guess_next;
    logic             one_hot;
    logic             k_zero;
    logic             finish_now;

    assign one_hot    = $onehot({cmp_equals, cmp_larger, cmp_smaller});
    assign k_zero     = (k_reg == '0);
    // Every outcome other than a clean narrowing step terminates the search here.
    assign finish_now = !one_hot || cmp_equals || (cmp_larger && k_zero);

    // Per-bit narrowing: drop the trial bit on "smaller", arm the next lower bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_next
            always_comb begin
                guess_next[gi] = guess[gi];
                if (cmp_smaller && (k_reg == KW'(gi)))
                    guess_next[gi] = 1'b0;
                if (!k_zero && ((k_reg - KW'(1)) == KW'(gi)))
                    guess_next[gi] = 1'b1;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            guess     <= '0;
            k_reg     <= '0;
            found     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        guess     <= {1'b1, {(WIDTH-1){1'b0}}};
                        k_reg     <= KW'(WIDTH - 1);
                        found     <= '0;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= TRIAL;
                    end
                end
                TRIAL: begin
                    if (finish_now) begin
                        found     <= guess;
                        error     <= !one_hot || cmp_larger;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        guess     <= '0;
                        state_reg <= IDLE;
                    end else if (k_zero) begin
                        // Only "smaller" reaches here at the LSB, so A is guess with bit 0 cleared.
                        found     <= guess_next;
                        error     <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        guess     <= '0;
                        state_reg <= IDLE;
                    end else begin
                        guess <= guess_next;
                        k_reg <= k_reg - KW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: WIDTH=4 and WIDTH=8 instances searched against a comparator
// model, with expected trial sequences derived arithmetically from the operand.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sel;          // 0 -> WIDTH=4 instance, 1 -> WIDTH=8 instance
    int         force_kind;   // 0 normal, 1 flags 000, 2 forced larger
    logic [7:0] a4, a8;

    logic [3:0] guess4, found4;
    logic       busy4, done4, error4;
    logic [7:0] guess8, found8;
    logic       busy8, done8, error8;
    logic [2:0] fl4, fl8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] cmp_model(input logic [7:0] a, input logic [7:0] g, input int kind);
        if (kind == 1) return 3'b000;
        if (kind == 2) return 3'b010;
        return {a == g, a > g, a < g};
    endfunction

    always_comb begin
        fl4 = cmp_model(a4, {4'b0, guess4}, sel ? 0 : force_kind);
        fl8 = cmp_model(a8, guess8, sel ? force_kind : 0);
    end

    sar_search #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start && !sel),
        .cmp_equals(fl4[2]), .cmp_larger(fl4[1]), .cmp_smaller(fl4[0]),
        .guess(guess4), .busy(busy4), .done(done4), .found(found4), .error(error4)
    );

    sar_search #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start && sel),
        .cmp_equals(fl8[2]), .cmp_larger(fl8[1]), .cmp_smaller(fl8[0]),
        .guess(guess8), .busy(busy8), .done(done8), .found(found8), .error(error8)
    );

    logic [7:0] og, of;
    logic       ob, od, oe;
    always_comb begin
        og = sel ? guess8 : {4'b0, guess4};
        of = sel ? found8 : {4'b0, found4};
        ob = sel ? busy8  : busy4;
        od = sel ? done8  : done4;
        oe = sel ? error8 : error4;
    end

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Binary search presents trial t with all bits above position w-t taken from A,
    // a one at position w-t, and zeros below.
    function automatic logic [7:0] exp_guess(input logic [7:0] a, input int t, input int w);
        int b = w - t;
        logic [7:0] hi = (a >> (b + 1)) << (b + 1);
        return hi | (8'd1 << b);
    endfunction

    // The search hits A exactly once its lowest set bit is tried; A=0 runs all trials.
    function automatic int exp_trials(input logic [7:0] a, input int w);
        int tz = 0;
        if (a == 0) return w;
        while (a[tz] == 1'b0) tz++;
        return w - tz;
    endfunction

    task automatic begin_search(input logic s, input logic [7:0] a);
        sel   = s;
        if (s) a8 = a; else a4 = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic follow(input int w, input logic [7:0] a, input int ft, input int fk,
                          input int pt, input int rt, output bit ended);
        int t = 1;
        int et;
        logic [7:0] ef;
        int ee;
        ended = 1'b0;
        forever begin
            if (t == rt) begin
                reset = 1'b1;
                #1;
                check("rst_guess", og, 0);
                check("rst_busy", ob, 0);
                check("rst_done", od, 0);
                check("rst_found", of, 0);
                check("rst_error", oe, 0);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                check("rst_nodone", od, 0);
                check("rst_idle_busy", ob, 0);
                return;
            end
            check($sformatf("guess_a%0d_t%0d", a, t), og, exp_guess(a, t, w));
            check("busy_in_trial", ob, 1);
            check("done_in_trial", od, 0);
            force_kind = (t == ft) ? fk : 0;
            start      = (t == pt);
            @(negedge clk);
            force_kind = 0;
            start      = 1'b0;
            if (od) break;
            t++;
            if (t > w) begin
                check("trial_budget", t, w);
                break;
            end
        end
        if (ft > 0) begin
            et = ft; ef = exp_guess(a, ft, w); ee = 1;
        end else begin
            et = exp_trials(a, w); ef = a; ee = 0;
        end
        check($sformatf("trials_a%0d", a), t, et);
        check($sformatf("found_a%0d", a), of, ef);
        check("error", oe, ee);
        check("done_pulse", od, 1);
        check("busy_after", ob, 0);
        check("guess_after", og, 0);
        ended = 1'b1;
    endtask

    task automatic run(input logic s, input logic [7:0] a, input int ft, input int fk,
                       input int pt, input int rt);
        bit ended;
        begin_search(s, a);
        follow(s ? 8 : 4, a, ft, fk, pt, rt, ended);
        if (ended) begin
            @(negedge clk);
            check("done_one_cycle", od, 0);
            check("found_held", of, (ft > 0) ? exp_guess(a, ft, s ? 8 : 4) : a);
        end
    endtask

    initial begin
        bit ended;
        reset = 1'b1; start = 1'b0; sel = 1'b0; force_kind = 0; a4 = 0; a8 = 0;
        @(negedge clk);
        check("reset_guess", og, 0);
        check("reset_busy", ob, 0);
        check("reset_done", od, 0);
        check("reset_found", of, 0);
        check("reset_error", oe, 0);
        reset = 1'b0;
        @(negedge clk);

        run(0, 8'd0, 0, 0, 0, 0);
        run(0, 8'd8, 0, 0, 0, 0);
        run(0, 8'd11, 0, 0, 0, 0);
        run(0, 8'd15, 0, 0, 0, 0);
        for (int v = 0; v < 16; v++) run(0, v[7:0], 0, 0, 0, 0);

        run(0, 8'd11, 2, 1, 0, 0);     // flags 000 on trial 2 -> found 12
        run(0, 8'd5, 4, 2, 0, 0);      // larger on the LSB trial
        run(0, 8'd11, 0, 0, 2, 0);     // start pulsed mid-search
        run(0, 8'd13, 0, 0, 0, 3);     // reset on trial 3

        // Restart from the done cycle.
        begin_search(0, 8'd6);
        follow(4, 8'd6, 0, 0, 0, 0, ended);
        begin_search(0, 8'd9);
        follow(4, 8'd9, 0, 0, 0, 0, ended);
        @(negedge clk);
        check("restart_done_drop", od, 0);

        for (int v = 0; v < 256; v++) run(1, v[7:0], 0, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra = 8'($urandom_range(0, 255));
            int rp = int'($urandom_range(1, 8));
            run(1, ra, 0, 0, rp, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
